// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers, with bursts of up to BURST_LEN beats.
// Define FIFO_ARB_STATS_EN to add the saturating wr_beats / full_stalls counters.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic              fifo_full,
  output logic              fifo_wrtEn,
  output logic [DW-1:0]     fifo_wrtData,
  output logic [2:0]        grant_id,
  output logic              busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]       wr_beats,
  output logic [15:0]       full_stalls
`endif
);

  // Handshake: a beat transfers on a rising edge where req_valid[i] & req_ready[i];
  // the producer holds valid and data stable until that edge.
  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_e     state_q, state_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] owner_q, owner_d;
  logic [4:0] beat_cnt_q, beat_cnt_d;

  logic       any_valid;
  logic [2:0] sel;
  logic       owner_valid;

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (int'(i) == NREQ - 1) ? 3'd0 : i + 3'd1;
  endfunction

  // Scan from the highest offset down so the closest valid requester to rr_ptr wins.
  always_comb begin
    any_valid = 1'b0;
    sel       = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        any_valid = 1'b1;
        sel       = 3'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign owner_valid = |(req_valid & (ONE << owner_q));

  always_comb begin
    req_ready = '0;
    grant_id  = 3'd0;
    if (rst_) begin
      if (state_q == BURST) begin
        req_ready = fifo_full ? '0 : (ONE << owner_q);
        grant_id  = owner_q;
      end else if (any_valid && !fifo_full) begin
        req_ready = ONE << sel;
        grant_id  = sel;
      end
    end
  end

  assign busy         = rst_ && (state_q == BURST);
  assign fifo_wrtEn   = |(req_valid & req_ready);
  assign fifo_wrtData = req_data[int'(grant_id)*DW +: DW];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid && !fifo_full) begin
          if (BURST_LEN > 1) begin
            state_d    = BURST;
            owner_d    = sel;
            beat_cnt_d = 5'd1;
          end else begin
            rr_ptr_d = next_idx(sel);
          end
        end
      end
      BURST: begin
        // A dropped valid releases the port without a write; a full FIFO just holds.
        if (!owner_valid) begin
          state_d    = IDLE;
          rr_ptr_d   = next_idx(owner_q);
          beat_cnt_d = 5'd0;
        end else if (!fifo_full) begin
          if (int'(beat_cnt_q) + 1 == BURST_LEN) begin
            state_d    = IDLE;
            rr_ptr_d   = next_idx(owner_q);
            beat_cnt_d = 5'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 3'd0;
      owner_q    <= 3'd0;
      beat_cnt_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] wr_beats_q, full_stalls_q;
  logic        eligible_valid;

  assign eligible_valid = (state_q == BURST) ? owner_valid : any_valid;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_beats_q    <= 16'd0;
      full_stalls_q <= 16'd0;
    end else begin
      if (fifo_wrtEn && wr_beats_q != 16'hFFFF) wr_beats_q <= wr_beats_q + 16'd1;
      if (eligible_valid && fifo_full && full_stalls_q != 16'hFFFF)
        full_stalls_q <= full_stalls_q + 16'd1;
    end
  end

  assign wr_beats    = wr_beats_q;
  assign full_stalls = full_stalls_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: random producers, a 128-deep FIFO model and a rule-level reference arbiter.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BL   = 4;
  localparam int W    = 3 + DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_ = 1'b0;

  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data  = '0;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full, fifo_wrtEn, busy;
  logic [DW-1:0]      fifo_wrtData;
  logic [2:0]         grant_id;
  logic               force_full = 1'b0;
  logic               rd_en = 1'b0;

  logic [NREQ-1:0]    v1 = '0;
  logic [NREQ*DW-1:0] d1 = '0;
  logic [NREQ-1:0]    ready1;
  logic               wen1, busy1;
  logic [DW-1:0]      wd1;
  logic [2:0]         gid1;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] wr_beats, full_stalls, wb1, fs1;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wrtEn(fifo_wrtEn),
    .fifo_wrtData(fifo_wrtData), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .wr_beats(wr_beats), .full_stalls(full_stalls)
`endif
  );

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_(rst_), .req_valid(v1), .req_data(d1),
    .req_ready(ready1), .fifo_full(1'b0), .fifo_wrtEn(wen1),
    .fifo_wrtData(wd1), .grant_id(gid1), .busy(busy1)
`ifdef FIFO_ARB_STATS_EN
    , .wr_beats(wb1), .full_stalls(fs1)
`endif
  );

  // 128x8 FIFO model
  logic [DW-1:0] mem [128];
  logic [6:0]    wp = '0, rp = '0;
  logic [7:0]    fcnt = '0;
  assign fifo_full = (fcnt == 8'd128) || force_full;

  always @(posedge clk) begin
    if (!rst_) begin
      wp <= '0; rp <= '0; fcnt <= '0;
    end else begin
      if (fifo_wrtEn && fcnt != 8'd128) begin
        mem[wp] <= fifo_wrtData;
        wp <= wp + 7'd1;
      end
      if (rd_en && fcnt != 8'd0) rp <= rp + 7'd1;
      fcnt <= fcnt + 8'(fifo_wrtEn && fcnt != 8'd128) - 8'(rd_en && fcnt != 8'd0);
    end
  end

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] rb_q[$];
  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // reference model: owner index or -1, beats used by the owner, next start of the rotation
  int m_owner = -1, m_beats = 0, m_ptr = 0, m_wr = 0, m_stall = 0;

  always @(negedge clk) begin
    int exp_id, sel;
    logic [NREQ-1:0] exp_rdy;
    logic busy_exp;
    logic [DW-1:0] d;
    #1;
    exp_id = -1; sel = -1; exp_rdy = '0;
    busy_exp = rst_ && (m_owner >= 0);
    if (!rst_) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_wr = 0; m_stall = 0;
      exp_q.delete(); rb_q.delete();
    end else if (m_owner >= 0) begin
      if (!fifo_full) exp_rdy[m_owner] = 1'b1;
      if (!req_valid[m_owner]) begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
      end else if (fifo_full) begin
        m_stall++;
      end else begin
        exp_id = m_owner; m_beats++;
        if (m_beats == BL) begin m_ptr = (m_owner + 1) % NREQ; m_owner = -1; end
      end
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (sel < 0 && req_valid[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
      if (sel >= 0 && fifo_full) m_stall++;
      else if (sel >= 0) begin
        exp_id = sel; exp_rdy[sel] = 1'b1;
        if (BL == 1) m_ptr = (sel + 1) % NREQ;
        else begin m_owner = sel; m_beats = 1; end
      end
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(busy_exp));
    if (exp_id >= 0) begin
      d = req_data[exp_id*DW +: DW];
      exp_q.push_back({3'(exp_id), d});
      rb_q.push_back(d);
      m_wr++;
    end
  end

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    #2;
    if (fifo_wrtEn) begin
      if (exp_q.size() == 0) check("write_en", 32'(fifo_wrtEn), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("grant_id", 32'(grant_id), 32'(e[W-1:DW]));
        check("wr_data", 32'(fifo_wrtData), 32'(e[DW-1:0]));
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      check("write_en", 32'(fifo_wrtEn), 32'd1);
    end
    if (rst_ && rd_en && fcnt != 8'd0) begin
      if (rb_q.size() == 0) check("readback_extra", 32'(fcnt), 32'd0);
      else check("readback", 32'(mem[rp]), 32'(rb_q.pop_front()));
    end
  end

  // driver
  logic [NREQ-1:0] acc = '0;

  task automatic cycle(input logic [NREQ-1:0] want, input logic rd, input logic ff, input logic rs);
    @(negedge clk);
    rst_ = rs; rd_en = rd; force_full = ff;
    for (int i = 0; i < NREQ; i++) if (acc[i]) req_valid[i] = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!req_valid[i] && want[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = DW'($urandom);
      end
    #3 acc = req_valid & req_ready;
  endtask

  task automatic drain();
    int n = 0;
    while ((req_valid != '0 || fcnt != 8'd0) && n < 400) begin
      cycle('0, 1'b1, 1'b0, 1'b1); n++;
    end
    check("drain_done", {20'd0, req_valid, fcnt}, 32'd0);
    cycle('0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wb0;
`endif
    // reset with every requester valid
    repeat (3) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    check("reset_wen", 32'(fifo_wrtEn), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);
    cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    check("first_grant", 32'(grant_id), 32'd0);
    check("first_wen", 32'(fifo_wrtEn), 32'd1);
`ifdef FIFO_ARB_STATS_EN
    check("stats_after_reset", {wr_beats, full_stalls}, 32'd0);
`endif

    // continuous bursts, then a reset in the middle of one
    repeat (18) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    repeat (2) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    repeat (7) cycle(4'b1111, 1'b1, 1'b0, 1'b1);

    // random traffic with random reads and forced full
    repeat (300) cycle(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 7) == 0, 1'b1);
    drain();

    // requester 2 stalled by full mid-burst
    repeat (2) cycle(4'b0100, 1'b1, 1'b0, 1'b1);
    repeat (3) begin
      cycle(4'b0100, 1'b1, 1'b1, 1'b1);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_owner", 32'(grant_id), 32'd2);
      check("stall_wen", 32'(fifo_wrtEn), 32'd0);
    end
    repeat (2) begin
      cycle(4'b0100, 1'b1, 1'b0, 1'b1);
      check("resume_busy", 32'(busy), 32'd1);
    end
    drain();

    // requester 1 releases after two beats; rotation continues at 2
    repeat (2) cycle(4'b0010, 1'b1, 1'b0, 1'b1);
    cycle(4'b1001, 1'b1, 1'b0, 1'b1);
    check("release_wen", 32'(fifo_wrtEn), 32'd0);
    cycle(4'b1011, 1'b1, 1'b0, 1'b1);
    check("after_release_grant", 32'(grant_id), 32'd3);
    repeat (4) cycle(4'b1011, 1'b1, 1'b0, 1'b1);
    drain();

    // fill the FIFO with no reads, stall on full, then read everything back
`ifdef FIFO_ARB_STATS_EN
    wb0 = wr_beats;
`endif
    n = 0;
    while (fcnt != 8'd128 && n < 600) begin
      cycle(NREQ'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b1); n++;
    end
    check("fifo_filled", 32'(fcnt), 32'd128);
`ifdef FIFO_ARB_STATS_EN
    check("wr_beats_fill", 32'(wr_beats - wb0), 32'd128);
`endif
    repeat (6) begin
      cycle(4'b1111, 1'b0, 1'b0, 1'b1);
      check("full_ready", 32'(req_ready), 32'd0);
    end
    drain();
    check("readback_left", rb_q.size(), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    check("wr_beats", 32'(wr_beats), 32'(16'(m_wr)));
    check("full_stalls", 32'(full_stalls), 32'(16'(m_stall)));
`endif

    // per-beat round-robin instance: lone requester 3, then 1 and 3 alternating
    req_valid = '0;
    d1[3*DW +: DW] = DW'($urandom);
    d1[1*DW +: DW] = DW'($urandom);
    repeat (6) begin
      @(negedge clk);
      v1 = 4'b1000;
      #2;
      check("bl1_ready", 32'(ready1), 32'h8);
      check("bl1_grant", 32'(gid1), 32'd3);
      check("bl1_data", 32'(wd1), 32'(d1[3*DW +: DW]));
      check("bl1_busy", 32'(busy1), 32'd0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      v1 = 4'b1010;
      #2;
      check("bl1_alt_grant", 32'(gid1), (c % 2 == 0) ? 32'd1 : 32'd3);
      check("bl1_alt_wen", 32'(wen1), 32'd1);
    end
    @(negedge clk);
    v1 = '0;
    #2;
    check("bl1_idle_wen", 32'(wen1), 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish, limit 300000 reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
